operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Front-end stage of the FPGA half-precision calculator. It sits directly upstream of `top`, the FP arithmetic core.
- Debounces the raw `enable` pushbutton and uses successive presses to latch operand A, then operand B, from the 16 slide switches.
- Issues a one-cycle `start` to the core, then waits for `core_ready`, with a watchdog timeout.
- Exposes phase and status for board LEDs.

Parameters:
- WIDTH, 16, operand width (switch count)
- DEBOUNCE_CYCLES, 500000, cycles `enable` must be stable before a level change is accepted (10 ms at 50 MHz)
- TIMEOUT_CYCLES, 1024, maximum number of WAIT_DONE cycles before the core is declared hung

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  raw pushbutton, asynchronous and bouncy
- switches  in  WIDTH  slide switches, quasi-static
- core_ready  in  1  completion from the FP core
- opa  out  WIDTH  latched operand A
- opb  out  WIDTH  latched operand B
- start  out  1  one-cycle issue pulse to the core
- busy  out  1  high from issue until completion or timeout
- result_valid  out  1  core finished normally
- timeout  out  1  core failed to respond within TIMEOUT_CYCLES
- phase  out  2  LED code: 0 = CAP_A, 1 = CAP_B, 2 = RUN, 3 = SHOW

Behaviour:
- Reset:
  - rst asserted → all outputs 0 and the FSM goes to CAP_A immediately (async), including mid-operation.
  - Sync flops, debounce counter, debounced level and timeout counter are all cleared to 0.
- Input path:
  - `enable` passes through a 2-flop synchroniser to give `en_s`.
  - If `en_s` ≠ `db_level`, the counter increments; when it reaches DEBOUNCE_CYCLES-1 and still differs, `db_level` takes `en_s` and the counter clears.
  - If `en_s` = `db_level`, the counter clears, so any bounce restarts the count.
- Press event:
  - `press` = `db_level` rising edge against a registered copy of `db_level`; it is one cycle wide.
  - With `enable` held stable high, the FSM acts at the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples `enable` high.
  - Release does not generate an event.
- FSM states: CAP_A, CAP_B, ISSUE, WAIT_DONE, SHOW.
  - CAP_A: on `press`, `opa` ← `switches`, go to CAP_B.
  - CAP_B: on `press`, `opb` ← `switches`, go to ISSUE.
  - ISSUE: lasts exactly one cycle; `start` = 1 and `busy` = 1; go to WAIT_DONE. `core_ready` is ignored in this cycle.
  - WAIT_DONE: `busy` = 1; the timeout counter is cleared on entry.
    - `core_ready` = 1 → `result_valid` ← 1, go to SHOW.
    - Otherwise the counter increments; after TIMEOUT_CYCLES WAIT_DONE cycles with no ready → `timeout` ← 1, go to SHOW.
    - `core_ready` on the expiry cycle → ready wins: `result_valid` = 1, `timeout` = 0.
  - SHOW: `busy` = 0; `result_valid` / `timeout` are held.
    - On `press`: clear both, `opa` ← `switches`, go to CAP_B, so a new A is taken in the same press.
- Ignored inputs:
  - `press` in ISSUE or WAIT_DONE is dropped, not queued.
  - `core_ready` outside WAIT_DONE is ignored.
- Output registering and holds:
  - `start`, `busy`, `result_valid`, `timeout` and `phase` are registered (glitch-free).
  - `opa` / `opb` hold their values until recaptured; both are stable from ISSUE through SHOW.
  - `phase` = 2 covers both ISSUE and WAIT_DONE.
- Counter widths:
  - $clog2 of the respective parameter.
  - The debounce counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

Decomposition:
- Shared package `calc_pkg`:
  - state enum (CAP_A, CAP_B, ISSUE, WAIT_DONE, SHOW)
  - phase LED encodings
  - default WIDTH (16)
- Sub-module `btn_debounce`:
  - contains the synchroniser, debounce counter and edge detect
  - parameter DEBOUNCE_CYCLES
  - ports clk, rst, btn_raw, level, press
  - reusable for other board buttons

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16):
1. Normal run:
   - Stimulus: press with `switches`=16'h3C00, then with 16'h4000; pulse `core_ready` 5 cycles after `start`.
   - Required: `opa`=3C00, `opb`=4000; `start` high exactly 1 cycle, on the cycle after the `opb` capture; `busy`=1; after ready, `result_valid`=1, `busy`=0, `phase`=3.
2. Bounce:
   - Stimulus: toggle `enable` every 2 cycles for 30 cycles, then hold low.
   - Required: no capture; `phase` stays 0; `opa`=0.
3. Ignored inputs:
   - Stimulus: press during WAIT_DONE; `core_ready` pulse while in CAP_A.
   - Required: state is unchanged in both cases, and the dropped press is not replayed later.
4. Timeout and restart:
   - Stimulus: never assert `core_ready`.
   - Required: `timeout`=1 after 16 WAIT_DONE cycles, `phase`=3, `busy`=0.
   - Then press with `switches`=16'h1234 → `opa`=1234, `timeout`=0, `phase`=1.
5. Race:
   - Stimulus: assert `core_ready` on the 16th WAIT_DONE cycle.
   - Required: `result_valid`=1, `timeout`=0.
6. Async reset:
   - Stimulus: assert `rst` between clock edges while in WAIT_DONE.
   - Required: all outputs read 0 and `phase`=0 before the next edge; after release, a single press captures into `opa`.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the half-precision calculator front end: sequencer states,
// LED phase codes and the default operand width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        CAP_A     = 3'd0,
        CAP_B     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        SHOW      = 3'd4
    } state_t;

    localparam logic [1:0] PHASE_CAP_A = 2'd0;
    localparam logic [1:0] PHASE_CAP_B = 2'd1;
    localparam logic [1:0] PHASE_RUN   = 2'd2;
    localparam logic [1:0] PHASE_SHOW  = 2'd3;

    // ISSUE and WAIT_DONE share one LED code
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            CAP_A:            phase_of = PHASE_CAP_A;
            CAP_B:            phase_of = PHASE_CAP_B;
            ISSUE, WAIT_DONE: phase_of = PHASE_RUN;
            SHOW:             phase_of = PHASE_SHOW;
            default:          phase_of = PHASE_CAP_A;
        endcase
    endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// Board-side bundle of the operand sequencer: button, switches, core handshake
// and LED status.
interface operand_sequencer_if
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             enable;
    logic [WIDTH-1:0] switches;
    logic             core_ready;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             start;
    logic             busy;
    logic             result_valid;
    logic             timeout;
    logic [1:0]       phase;

    // The sequencer issues work to the core, so it is the master
    modport master (
        input  enable, switches, core_ready,
        output opa, opb, start, busy, result_valid, timeout, phase
    );

    modport slave (
        output enable, switches, core_ready,
        input  opa, opb, start, busy, result_valid, timeout, phase
    );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle rising-edge press pulse. Reusable for any board button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Any return to the accepted level restarts the count, so bounce never accumulates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            level_d <= level;
            if (sync_p1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/operand_sequencer.sv
// Calculator front end: successive debounced presses latch operand A then B,
// fire a one-cycle start to the FP core and wait for ready under a watchdog.
module operand_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clk,
    input  logic rst,
    operand_sequencer_if.master bus
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic press;
    logic level;
    logic take;

    state_t           state, state_n;
    logic [WIDTH-1:0] opa_q, opa_n;
    logic [WIDTH-1:0] opb_q, opb_n;
    logic             rv_q, rv_n;
    logic             to_q, to_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic             start_q;
    logic             busy_q;
    logic [1:0]       phase_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enable_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.enable),
        .level   (level),
        .press   (press)
    );

    assign take = press & level;

    always_comb begin
        state_n = state;
        opa_n   = opa_q;
        opb_n   = opb_q;
        rv_n    = rv_q;
        to_n    = to_q;
        tcnt_n  = tcnt;
        case (state)
            CAP_A: begin
                if (take) begin
                    opa_n   = bus.switches;
                    state_n = CAP_B;
                end
            end
            CAP_B: begin
                if (take) begin
                    opb_n   = bus.switches;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_n  = '0;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Ready on the expiry cycle still counts as a normal finish
                if (bus.core_ready) begin
                    rv_n    = 1'b1;
                    state_n = SHOW;
                end else if (tcnt == TCNT_LAST) begin
                    to_n    = 1'b1;
                    state_n = SHOW;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            SHOW: begin
                if (take) begin
                    rv_n    = 1'b0;
                    to_n    = 1'b0;
                    opa_n   = bus.switches;
                    state_n = CAP_B;
                end
            end
            default: state_n = CAP_A;
        endcase
    end

    // Status outputs are registered from the next state so LEDs never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CAP_A;
            opa_q   <= '0;
            opb_q   <= '0;
            rv_q    <= 1'b0;
            to_q    <= 1'b0;
            tcnt    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            phase_q <= PHASE_CAP_A;
        end else begin
            state   <= state_n;
            opa_q   <= opa_n;
            opb_q   <= opb_n;
            rv_q    <= rv_n;
            to_q    <= to_n;
            tcnt    <= tcnt_n;
            start_q <= (state_n == ISSUE);
            busy_q  <= (state_n == ISSUE) || (state_n == WAIT_DONE);
            phase_q <= phase_of(state_n);
        end
    end

    assign bus.opa          = opa_q;
    assign bus.opb          = opb_q;
    assign bus.start        = start_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = rv_q;
    assign bus.timeout      = to_q;
    assign bus.phase        = phase_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a small debounce window and a
// short watchdog; operands and outcomes are scoreboarded through queues.
module tb_operand_sequencer;
    import calc_pkg::*;

    localparam int WIDTH = 16;
    localparam int DC    = 4;
    localparam int TC    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

    operand_sequencer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DC),
        .TIMEOUT_CYCLES  (TC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] opnd_q[$];
    logic [1:0]       outcome_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_opnd(input string tag, input logic [WIDTH-1:0] obs);
        if (opnd_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            check(tag, {16'h0, obs}, {16'h0, opnd_q.pop_front()});
        end
    endtask

    task automatic check_outcome(input string tag);
        if (outcome_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=%0b expected=<empty scoreboard>", tag,
                   {bus.result_valid, bus.timeout});
        end else begin
            check(tag, {30'h0, bus.result_valid, bus.timeout}, {30'h0, outcome_q.pop_front()});
        end
    endtask

    // Hold the button high; the sequencer acts on the 7th edge (DC+3)
    task automatic press_begin(input logic [WIDTH-1:0] sw);
        bus.switches = sw;
        bus.enable   = 1'b1;
        repeat (DC + 3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_btn(input int n);
        bus.enable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_opa"},   {16'h0, bus.opa}, 32'h0);
        check({tag, "_opb"},   {16'h0, bus.opb}, 32'h0);
        check({tag, "_start"}, {31'h0, bus.start}, 32'h0);
        check({tag, "_busy"},  {31'h0, bus.busy}, 32'h0);
        check({tag, "_rv"},    {31'h0, bus.result_valid}, 32'h0);
        check({tag, "_to"},    {31'h0, bus.timeout}, 32'h0);
        check({tag, "_phase"}, {30'h0, bus.phase}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable     = 1'b0;
        bus.switches   = '0;
        bus.core_ready = 1'b0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // core_ready while capturing A is ignored
        bus.core_ready = 1'b1;
        @(negedge clk);
        bus.core_ready = 1'b0;
        @(negedge clk);
        check("ready_in_cap_a_phase", {30'h0, bus.phase}, {30'h0, PHASE_CAP_A});
        check("ready_in_cap_a_rv",    {31'h0, bus.result_valid}, 32'h0);
        check("ready_in_cap_a_busy",  {31'h0, bus.busy}, 32'h0);

        // Bounce: 2-cycle runs never reach the 4-cycle window
        bus.switches = 16'hBEEF;
        for (int i = 0; i < 15; i++) begin
            bus.enable = ~bus.enable;
            repeat (2) @(negedge clk);
        end
        bus.enable = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_phase", {30'h0, bus.phase}, 32'h0);
        check("bounce_opa",   {16'h0, bus.opa}, 32'h0);

        // Normal run
        opnd_q.push_back(16'h3C00);
        press_begin(16'h3C00);
        check_opnd("t1_opa", bus.opa);
        check("t1_phase_capb", {30'h0, bus.phase}, {30'h0, PHASE_CAP_B});
        check("t1_no_start_yet", {31'h0, bus.start}, 32'h0);
        release_btn(8);
        opnd_q.push_back(16'h4000);
        press_begin(16'h4000);
        check_opnd("t1_opb", bus.opb);
        check("t1_start_hi",  {31'h0, bus.start}, 32'h1);
        check("t1_busy_iss",  {31'h0, bus.busy}, 32'h1);
        check("t1_phase_run", {30'h0, bus.phase}, {30'h0, PHASE_RUN});
        @(negedge clk);
        check("t1_start_lo",  {31'h0, bus.start}, 32'h0);
        check("t1_busy_wait", {31'h0, bus.busy}, 32'h1);
        repeat (3) @(negedge clk);
        bus.core_ready = 1'b1;
        outcome_q.push_back(2'b10);
        @(negedge clk);
        bus.core_ready = 1'b0;
        check_outcome("t1_outcome");
        check("t1_busy_done",   {31'h0, bus.busy}, 32'h0);
        check("t1_phase_show",  {30'h0, bus.phase}, {30'h0, PHASE_SHOW});
        check("t1_opa_stable",  {16'h0, bus.opa}, 32'h3C00);
        check("t1_opb_stable",  {16'h0, bus.opb}, 32'h4000);
        release_btn(8);

        // New A from SHOW, then a press during WAIT_DONE that must be dropped
        opnd_q.push_back(16'h1111);
        press_begin(16'h1111);
        check_opnd("t3_opa", bus.opa);
        check("t3_rv_cleared", {31'h0, bus.result_valid}, 32'h0);
        check("t3_phase_capb", {30'h0, bus.phase}, {30'h0, PHASE_CAP_B});
        release_btn(8);
        opnd_q.push_back(16'h2222);
        press_begin(16'h2222);
        check_opnd("t3_opb", bus.opb);
        release_btn(7);
        press_begin(16'h5555);
        check("t3_drop_phase", {30'h0, bus.phase}, {30'h0, PHASE_RUN});
        check("t3_drop_busy",  {31'h0, bus.busy}, 32'h1);
        check("t3_drop_opa",   {16'h0, bus.opa}, 32'h1111);
        check("t3_drop_opb",   {16'h0, bus.opb}, 32'h2222);

        // Timeout lands exactly after the 16th WAIT_DONE cycle
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_to_early",   {31'h0, bus.timeout}, 32'h0);
        check("t4_busy_early", {31'h0, bus.busy}, 32'h1);
        outcome_q.push_back(2'b01);
        @(negedge clk);
        check_outcome("t4_outcome");
        check("t4_phase_show", {30'h0, bus.phase}, {30'h0, PHASE_SHOW});
        check("t4_busy_done",  {31'h0, bus.busy}, 32'h0);
        repeat (10) @(negedge clk);
        check("t3_no_replay_phase", {30'h0, bus.phase}, {30'h0, PHASE_SHOW});
        check("t3_no_replay_opa",   {16'h0, bus.opa}, 32'h1111);
        opnd_q.push_back(16'h1234);
        press_begin(16'h1234);
        check_opnd("t4_restart_opa", bus.opa);
        check("t4_restart_to",    {31'h0, bus.timeout}, 32'h0);
        check("t4_restart_phase", {30'h0, bus.phase}, {30'h0, PHASE_CAP_B});
        release_btn(8);

        // Race: ready on the 16th WAIT_DONE cycle wins over the timeout
        opnd_q.push_back(16'hABCD);
        press_begin(16'hABCD);
        check_opnd("t5_opb", bus.opb);
        repeat (TC) @(negedge clk);
        check("t5_pre_rv",   {31'h0, bus.result_valid}, 32'h0);
        check("t5_pre_busy", {31'h0, bus.busy}, 32'h1);
        bus.core_ready = 1'b1;
        outcome_q.push_back(2'b10);
        @(negedge clk);
        bus.core_ready = 1'b0;
        check_outcome("t5_outcome");
        check("t5_phase_show", {30'h0, bus.phase}, {30'h0, PHASE_SHOW});
        release_btn(8);

        // Async reset mid-wait, then a single clean capture
        opnd_q.push_back(16'h7777);
        press_begin(16'h7777);
        check_opnd("t6_opa", bus.opa);
        release_btn(8);
        opnd_q.push_back(16'h8888);
        press_begin(16'h8888);
        check_opnd("t6_opb", bus.opb);
        release_btn(7);
        check("t6_in_wait", {30'h0, bus.phase}, {30'h0, PHASE_RUN});
        #2 rst = 1'b1;
        #1 check_all_zero("t6_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        opnd_q.push_back(16'h0F0F);
        press_begin(16'h0F0F);
        check_opnd("t6_post_opa", bus.opa);
        check("t6_post_phase", {30'h0, bus.phase}, {30'h0, PHASE_CAP_B});
        check("t6_post_opb",   {16'h0, bus.opb}, 32'h0);
        release_btn(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
